// File: rtl/div_pkg.sv
// Shared types and defaults for the programmable clock-enable divider.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package div_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Ratios below this collapse the period counter, so requests are clamped up.
  localparam int DIV_MIN      = 2;

  localparam int DFLT_CNT_W   = 8;
  localparam int DFLT_BURST_W = 8;
  localparam int DFLT_DIV     = 16;

endpackage

// File: rtl/div_core.sv
// Period counter with terminal-count compare; shared with the fixed divider.
// Latency: tc is combinational from the registered count (high on the last clock of a period).
// Backpressure: none; en pauses counting, clr forces the count back to zero.
module div_core import div_pkg::*; #(
  parameter int CNT_W = DFLT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] div,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  assign tc = en && (cnt == div - CNT_W'(1));

  // Count 0..div-1 while enabled; wrap on terminal count so a new div takes effect cleanly.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/div_sched.sv
// Sequencer for the programmable divider: config handshake, start/stop, burst counting.
// Latency: first flag N clocks after the start edge, then every N clocks; config commits at period boundaries.
// Backpressure: cfg_ready is always high in IDLE and drops in RUN while one config is pending.
module div_sched import div_pkg::*; #(
  parameter int CNT_W   = DFLT_CNT_W,
  parameter int BURST_W = DFLT_BURST_W,
  parameter int DEF_DIV = DFLT_DIV
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CNT_W-1:0]   cfg_div,
  input  logic [BURST_W-1:0] cfg_burst,
  input  logic               start,
  input  logic               stop,
  output logic               flag,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   cur_div
);

  state_t             state, state_d;
  logic [CNT_W-1:0]   div_reg, pend_div, acc_div;
  logic [BURST_W-1:0] burst_reg, pend_burst, pcnt, pcnt_inc;
  logic               pend, acc, go, tc, last, exit_run, run_en, core_clr;

  assign acc      = cfg_valid && cfg_ready;
  assign acc_div  = (cfg_div < CNT_W'(DIV_MIN)) ? CNT_W'(DIV_MIN) : cfg_div;
  assign go       = (state == IDLE) && start && !stop;
  // stop masks the terminal count so an abort never emits a flag.
  assign run_en   = (state == RUN) && !stop;
  assign core_clr = (state == IDLE) || stop;
  assign pcnt_inc = pcnt + BURST_W'(1);
  assign last     = tc && (burst_reg != '0) && (pcnt_inc == burst_reg);
  assign exit_run = (state == RUN) && (stop || last);

  assign busy      = (state == RUN);
  assign cfg_ready = (state == IDLE) || !pend;
  assign cur_div   = div_reg;

  div_core #(.CNT_W(CNT_W)) u_core (
    .clk (clk),
    .rst (rst),
    .en  (run_en),
    .clr (core_clr),
    .div (div_reg),
    .tc  (tc)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next-state: start launches a run, stop or the final burst flag ends it.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (go) state_d = RUN;
      RUN:     if (exit_run) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes, ratio/burst registers, pending slot and flag counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      flag       <= 1'b0;
      done       <= 1'b0;
      div_reg    <= CNT_W'(DEF_DIV);
      burst_reg  <= '0;
      pend       <= 1'b0;
      pend_div   <= '0;
      pend_burst <= '0;
      pcnt       <= '0;
    end else begin
      flag <= tc;
      done <= last;
      if (state == IDLE) begin
        if (acc) begin
          div_reg   <= acc_div;
          burst_reg <= cfg_burst;
        end
        if (go) pcnt <= '0;
      end else begin
        // Continuous runs saturate rather than wrap the flag count.
        if (tc && (pcnt != '1)) pcnt <= pcnt_inc;
        if (acc) begin
          // A config accepted on the exit cycle would otherwise be stranded in the pending slot.
          if (exit_run) begin
            div_reg   <= acc_div;
            burst_reg <= cfg_burst;
          end else begin
            pend_div   <= acc_div;
            pend_burst <= cfg_burst;
            pend       <= 1'b1;
          end
        end else if (pend && (tc || stop)) begin
          div_reg   <= pend_div;
          burst_reg <= pend_burst;
          pend      <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_div_sched.sv
// Self-checking bench for div_sched: directed table, hand sequences and random traffic vs a model.
// Latency: n/a.
// Backpressure: n/a.
module tb_div_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] cfg_div = '0;
  logic [7:0] cfg_burst = '0;
  logic       cfg_ready, flag, busy, done;
  logic [7:0] cur_div;

  int n_cmp = 0;
  int n_bad = 0;

  div_sched #(.CNT_W(8), .BURST_W(8), .DEF_DIV(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_div   (cfg_div),
    .cfg_burst (cfg_burst),
    .start     (start),
    .stop      (stop),
    .flag      (flag),
    .busy      (busy),
    .done      (done),
    .cur_div   (cur_div)
  );

  always #10 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model: remaining-clocks countdown per period ----------------
  bit m_ok = 0, m_run = 0, m_pend = 0, m_flag = 0, m_done = 0;
  int m_div = 16, m_burst = 0, m_pdiv = 0, m_pburst = 0, m_left = 0, m_nfl = 0;

  function automatic int clampd(input int d);
    return (d < 2) ? 2 : d;
  endfunction

  task automatic model_step();
    bit acc, fin;
    int ad, ab;
    acc = cfg_valid && (!m_run || !m_pend);
    ad  = clampd(int'(cfg_div));
    ab  = int'(cfg_burst);
    fin = 0;
    m_flag = 0;
    m_done = 0;
    if (rst) begin
      m_ok = 1; m_run = 0; m_div = 16; m_burst = 0; m_pend = 0;
    end else if (!m_run) begin
      if (acc) begin m_div = ad; m_burst = ab; end
      if (start && !stop) begin m_run = 1; m_left = m_div; m_nfl = 0; end
    end else if (stop) begin
      m_run = 0;
      if (acc) begin m_div = ad; m_burst = ab; end
      else if (m_pend) begin m_div = m_pdiv; m_burst = m_pburst; end
      m_pend = 0;
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_flag = 1;
        if (m_nfl < 255) m_nfl++;
        fin = (m_burst != 0) && (m_nfl == m_burst);
        if (m_pend) begin m_div = m_pdiv; m_burst = m_pburst; m_pend = 0; end
        m_left = m_div;
        if (fin) begin m_done = 1; m_run = 0; end
      end
      if (acc) begin
        if (fin) begin m_div = ad; m_burst = ab; end
        else begin m_pdiv = ad; m_pburst = ab; m_pend = 1; end
      end
    end
  endtask

  // Advance the model on every edge and compare all outputs shortly after.
  always @(posedge clk) begin
    model_step();
    #2;
    if (m_ok) begin
      chk("model_flag", flag, m_flag);
      chk("model_done", done, m_done);
      chk("model_busy", busy, m_run);
      chk("model_cfg_ready", cfg_ready, (!m_run || !m_pend));
      chk("model_cur_div", cur_div, m_div);
    end
  end

  // ---------------- directed table ----------------
  typedef struct {
    logic [7:0] div;
    logic [7:0] burst;
    int         exp_div;
    int         exp_n;
  } vec_t;

  vec_t tbl [6];

  task automatic run_row(input int i);
    int k, last, nfl;
    bit spc_ok, seen;
    k = 0; last = 0; nfl = 0; spc_ok = 1; seen = 0;
    cfg_valid = 1; cfg_div = tbl[i].div; cfg_burst = tbl[i].burst;
    tick();
    cfg_valid = 0;
    chk("row_cur_div", cur_div, tbl[i].exp_div);
    start = 1;
    tick();
    start = 0;
    while (k < 400 && !seen) begin
      tick();
      k++;
      if (flag) begin
        nfl++;
        if (k - last != tbl[i].exp_div) spc_ok = 0;
        last = k;
      end
      if (done) begin
        seen = 1;
        chk("row_done_with_flag", flag, 1);
        chk("row_busy_at_done", busy, 0);
        chk("row_flag_count", nfl, tbl[i].exp_n);
      end
    end
    chk("row_done_seen", seen, 1);
    chk("row_spacing", spc_ok, 1);
    tick();
    chk("row_flag_after", flag, 0);
    chk("row_busy_after", busy, 0);
  endtask

  initial begin
    tbl[0] = '{div: 8'd4,  burst: 8'd3, exp_div: 4,  exp_n: 3};
    tbl[1] = '{div: 8'd0,  burst: 8'd2, exp_div: 2,  exp_n: 2};
    tbl[2] = '{div: 8'd1,  burst: 8'd4, exp_div: 2,  exp_n: 4};
    tbl[3] = '{div: 8'd7,  burst: 8'd1, exp_div: 7,  exp_n: 1};
    tbl[4] = '{div: 8'd2,  burst: 8'd5, exp_div: 2,  exp_n: 5};
    tbl[5] = '{div: 8'd13, burst: 8'd2, exp_div: 13, exp_n: 2};

    // Reset state.
    rst = 1;
    tick();
    tick();
    chk("rst_flag", flag, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_cur_div", cur_div, 16);
    rst = 0;

    // Default ratio: start at cycle 5, flag every 16 clocks.
    repeat (4) tick();
    start = 1;
    tick();
    start = 0;
    chk("t1_busy", busy, 1);
    chk("t1_cur_div", cur_div, 16);
    for (int k = 1; k <= 48; k++) begin
      tick();
      chk("t1_flag", flag, (k % 16 == 0) ? 1 : 0);
    end
    stop = 1;
    tick();
    stop = 0;
    chk("t1_busy_stop", busy, 0);

    // Finite bursts including clamped ratios.
    for (int i = 0; i < 6; i++) run_row(i);

    // Ratio change mid-period commits at the next boundary.
    cfg_valid = 1; cfg_div = 8'd10; cfg_burst = 8'd0;
    tick();
    cfg_valid = 0;
    start = 1;
    tick();
    start = 0;
    repeat (3) tick();
    cfg_valid = 1; cfg_div = 8'd5;
    tick();
    cfg_valid = 0;
    chk("t3_ready_low", cfg_ready, 0);
    chk("t3_old_div", cur_div, 10);
    for (int k = 5; k <= 21; k++) begin
      tick();
      chk("t3_flag", flag, (k == 10 || k == 15 || k == 20) ? 1 : 0);
      if (k == 10) begin
        chk("t3_new_div", cur_div, 5);
        chk("t3_ready_back", cfg_ready, 1);
      end
    end

    // stop on the terminal-count cycle suppresses the flag.
    repeat (3) tick();
    stop = 1;
    tick();
    stop = 0;
    chk("t4_no_flag", flag, 0);
    chk("t4_busy", busy, 0);
    tick();
    chk("t4_flag_next", flag, 0);
    start = 1; stop = 1;
    tick();
    start = 0; stop = 0;
    chk("t4_startstop_busy", busy, 0);
    tick();
    chk("t4_idle_busy", busy, 0);
    chk("t4_idle_flag", flag, 0);

    // Reset mid-run drops a pending config.
    cfg_valid = 1; cfg_div = 8'd6; cfg_burst = 8'd0;
    tick();
    cfg_valid = 0;
    start = 1;
    tick();
    start = 0;
    repeat (2) tick();
    cfg_valid = 1; cfg_div = 8'd9;
    tick();
    cfg_valid = 0;
    chk("t6_pending", cfg_ready, 0);
    rst = 1;
    tick();
    rst = 0;
    chk("t6_flag", flag, 0);
    chk("t6_busy", busy, 0);
    chk("t6_cur_div", cur_div, 16);
    chk("t6_cfg_ready", cfg_ready, 1);
    start = 1;
    tick();
    start = 0;
    for (int k = 1; k <= 32; k++) begin
      tick();
      chk("t6_flag_run", flag, (k % 16 == 0) ? 1 : 0);
    end
    chk("t6_div_kept", cur_div, 16);
    stop = 1;
    tick();
    stop = 0;

    // Random traffic, checked every cycle by the model.
    for (int c = 0; c < 2500; c++) begin
      rst       = ($urandom_range(0, 299) == 0);
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_div   = 8'($urandom_range(0, 9));
      cfg_burst = 8'($urandom_range(0, 4));
      start     = ($urandom_range(0, 7) == 0);
      stop      = ($urandom_range(0, 39) == 0);
      tick();
    end
    rst = 0; cfg_valid = 0; start = 0; stop = 0;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
